data_bus: RTL and testbench
===========================

# data_bus

Data-side memory system for the single-cycle MIPS core. It sits directly downstream of the core's data port and consumes `memwrite`, `memaddr` and `memwritedata`. It returns `memreaddata` combinationally, because the core completes a load in one cycle. It decodes the address into a word RAM and a memory-mapped I/O page containing a GPIO output register, a synchronized switch input, and a compare timer with a sticky interrupt flag.

## Interface
- `RAM_WORDS`, 64: number of 32-bit data RAM words; power of two, ≤ 16384.
- `GPIN_W`, 16: width of switch input; zero-extended on read.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low: registers clear on a rising `clk` edge while `reset`==0.
- `memwrite`  in  1  write strobe from core.
- `memaddr`  in  32  byte address from core ALU; bits [1:0] ignored (word accesses only).
- `memwritedata`  in  32  store data.
- `memreaddata`  out  32  load data, combinational from `memaddr` and current state.
- `gpio_in`  in  GPIN_W  asynchronous switches.
- `gpio_out`  out  32  GPIO output register.
- `irq`  out  1  timer flag AND irq-enable (registered terms only).

## Operation
- Address map (word = `memaddr[31:2]`):
  - RAM: `memaddr[31:16]`==16'h0000 and word index `memaddr[15:2]` < RAM_WORDS. Out-of-range low-page addresses read 0; writes to them are dropped.
  - 0xFFFF_0000 GPIO_OUT: read/write.
  - 0xFFFF_0004 GPIO_IN: read-only; returns the 2-flop synchronized `gpio_in`, zero-extended.
  - 0xFFFF_0008 TCOUNT: read/write; a write loads the counter.
  - 0xFFFF_000C TCMP: read/write.
  - 0xFFFF_0010 TCTRL: bit0 EN, bit1 AUTOCLR, bit2 FLAG (sticky; write 1 clears, write 0 has no effect), bit3 IE; bits 31:4 read 0.
  - Any other address: reads 0; writes are ignored with no side effect.
- RAM: a write stores `memwritedata` at the edge when `memwrite`=1 and the address decodes to RAM. A read is asynchronous. RAM contents are not reset.
- Timer, evaluated each edge with EN=1:
  - If TCOUNT==TCMP: FLAG<=1, and TCOUNT<=0 when AUTOCLR=1, else TCOUNT+1.
  - Otherwise TCOUNT<=TCOUNT+1, modulo 2^32; 0xFFFF_FFFF wraps to 0 without setting FLAG unless TCMP matches.
  - With EN=0, TCOUNT holds and no match is detected.
- Simultaneous events:
  - A write to TCOUNT beats both increment and auto-clear.
  - A match beats a write-1-to-clear of FLAG in the same cycle, so FLAG stays 1.
  - A TCTRL write updates EN/AUTOCLR/IE at the edge. The match in that cycle uses the old EN.
  - A write to TCMP uses the old TCMP for that cycle's match.
- `irq` = FLAG & IE.

## Timing
- Reads: zero latency, valid in the same cycle `memaddr` is stable.
- Writes: take effect at the rising edge ending the cycle. A read in the following cycle returns the new value.
- GPIO_IN: a change on `gpio_in` is visible on reads after the 2nd rising edge.
- Timer: TCOUNT becomes equal to TCMP at edge k. FLAG and `irq` rise after edge k+1.
- Reset (`reset`=0 at an edge):
  - Cleared: GPIO_OUT, TCOUNT, TCMP, TCTRL (incl. FLAG), and both synchronizer stages. After reset, `gpio_out`=0 and `irq`=0.
  - `memreaddata` for any I/O address reads 0 after the reset edge.
  - Writes presented while `reset`=0 are discarded, including RAM writes.
  - Reset mid-count: TCOUNT reads 0 on the next cycle, and the timer stays stopped until EN is written.

## Test plan
- RAM: write 0xDEADBEEF to 0x0000_0010 → read of 0x0000_0010 = 0xDEADBEEF the next cycle; read of 0x0000_0014 is unaffected.
- Decode: write to 0x0000_0100 (index 64, out of range at RAM_WORDS=64) and to 0xFFFF_0020 → both read 0, and no RAM word changes.
- GPIO:
  - Write 0x0000_00A5 to 0xFFFF_0000 → `gpio_out`=0xA5 after the edge.
  - Drive `gpio_in`=16'h1234 → 0xFFFF_0004 reads 0x0000_1234 after 2 edges, and 0 before that.
- Timer: write TCMP=5, then TCTRL=0xB (EN, AUTOCLR, IE) → TCOUNT runs 0..5 then 0. FLAG and `irq` become 1 one cycle after TCOUNT=5. Writing TCTRL=0xF (bit2=1 clears FLAG, EN/AUTOCLR/IE stay set) drops `irq` the next cycle.
- Collision: write-1-to-clear FLAG in the same cycle TCOUNT==TCMP → FLAG stays 1.
- Collision: write TCOUNT=100 while running → reads 100 the next cycle, not an incremented value.
- Wrap and reset:
  - TCOUNT=0xFFFF_FFFE, TCMP=3, EN=1 → TCOUNT goes …FFFF, 0, 1. FLAG stays 0 until count 3.
  - Assert `reset`=0 for 1 edge mid-run → all I/O reads 0, `irq`=0, and the timer stays stopped.

Source files
------------

// File: rtl/data_bus.sv
// Data-side memory system for the single-cycle MIPS core: word RAM plus an
// I/O page with GPIO output, synchronized switch input and a compare timer.
module data_bus #(
   parameter int RAM_WORDS = 64,
   parameter int GPIN_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memwrite,
   input  logic [31:0]       memaddr,
   input  logic [31:0]       memwritedata,
   output logic [31:0]       memreaddata,
   input  logic [GPIN_W-1:0] gpio_in,
   output logic [31:0]       gpio_out,
   output logic              irq
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

   localparam logic [29:0] W_GPIO_OUT = 30'h3FFF_C000;
   localparam logic [29:0] W_GPIO_IN  = 30'h3FFF_C001;
   localparam logic [29:0] W_TCOUNT   = 30'h3FFF_C002;
   localparam logic [29:0] W_TCMP     = 30'h3FFF_C003;
   localparam logic [29:0] W_TCTRL    = 30'h3FFF_C004;

   logic [31:0]       ram [RAM_WORDS];
   logic [29:0]       word;
   logic              ram_hit;
   logic [AW-1:0]     ram_idx;
   logic              wr;
   logic [GPIN_W-1:0] sync1, sync2;
   logic [31:0]       tcount, tcmp;
   logic              en, autoclr, flag, ie;
   logic              match;
   logic              unused_bits;

   assign word    = memaddr[31:2];
   assign ram_hit = (memaddr[31:16] == 16'h0000) &&
                    ({18'b0, memaddr[15:2]} < 32'(RAM_WORDS));
   assign ram_idx = memaddr[AW+1:2];
   // Stores presented while reset is held are dropped everywhere, RAM included.
   assign wr      = memwrite && reset;
   assign match   = en && (tcount == tcmp);
   assign unused_bits = ^memaddr[1:0];

   always_ff @(posedge clk) begin
      if (wr && ram_hit)
         ram[ram_idx] <= memwritedata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         gpio_out <= '0;
      else if (wr && word == W_GPIO_OUT)
         gpio_out <= memwritedata;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         tcmp <= '0;
      else if (wr && word == W_TCMP)
         tcmp <= memwritedata;
   end

   // A software load of TCOUNT overrides both increment and auto-clear.
   always_ff @(posedge clk) begin
      if (!reset)
         tcount <= '0;
      else if (wr && word == W_TCOUNT)
         tcount <= memwritedata;
      else if (en)
         tcount <= (match && autoclr) ? 32'd0 : tcount + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         en      <= 1'b0;
         autoclr <= 1'b0;
         ie      <= 1'b0;
      end else if (wr && word == W_TCTRL) begin
         en      <= memwritedata[0];
         autoclr <= memwritedata[1];
         ie      <= memwritedata[3];
      end
   end

   // A match in the same cycle wins over write-1-to-clear.
   always_ff @(posedge clk) begin
      if (!reset)
         flag <= 1'b0;
      else if (match)
         flag <= 1'b1;
      else if (wr && word == W_TCTRL && memwritedata[2])
         flag <= 1'b0;
   end

   assign irq = flag && ie;

   always_comb begin
      memreaddata = 32'd0;
      if (ram_hit)
         memreaddata = ram[ram_idx];
      else if (word == W_GPIO_OUT)
         memreaddata = gpio_out;
      else if (word == W_GPIO_IN)
         memreaddata = 32'(sync2);
      else if (word == W_TCOUNT)
         memreaddata = tcount;
      else if (word == W_TCMP)
         memreaddata = tcmp;
      else if (word == W_TCTRL)
         memreaddata = {28'd0, ie, flag, autoclr, en};
   end

endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: directed RAM/decode/GPIO/timer scenarios
// plus a small random RAM pass, checked through an expected-value queue.
module tb_data_bus;

   localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0000;
   localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0004;
   localparam logic [31:0] A_TCOUNT   = 32'hFFFF_0008;
   localparam logic [31:0] A_TCMP     = 32'hFFFF_000C;
   localparam logic [31:0] A_TCTRL    = 32'hFFFF_0010;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] memaddr = '0;
   logic [31:0] memwritedata = '0;
   logic [31:0] memreaddata;
   logic [15:0] gpio_in = '0;
   logic [31:0] gpio_out;
   logic        irq;

   logic [31:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   data_bus #(.RAM_WORDS(64), .GPIN_W(16)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
      .memwritedata(memwritedata), .memreaddata(memreaddata),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1;
      memaddr = a;
      memwritedata = d;
      tick();
      memwrite = 1'b0;
   endtask

   // Expected value is queued with the stimulus and popped when the read settles.
   task automatic expect_read(input string tag, input logic [31:0] a, input logic [31:0] e);
      logic [31:0] got_exp;
      exp_q.push_back(e);
      memwrite = 1'b0;
      memaddr = a;
      #1;
      got_exp = exp_q.pop_front();
      check(tag, memreaddata, got_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdata [8];

      // reset
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      check("rst_gpio_out", gpio_out, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      expect_read("rst_tcount", A_TCOUNT, 32'd0);
      expect_read("rst_tctrl", A_TCTRL, 32'd0);

      // RAM
      write_word(32'h0000_0014, 32'h1111_2222);
      write_word(32'h0000_0010, 32'hDEAD_BEEF);
      expect_read("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
      expect_read("ram_14", 32'h0000_0014, 32'h1111_2222);
      expect_read("ram_bytelane", 32'h0000_0013, 32'hDEAD_BEEF);

      // random RAM pass
      for (int i = 0; i < 8; i++) begin
         rdata[i] = $urandom_range(32'hFFFF_FFFF, 0);
         write_word(32'h0000_0080 + 32'(i * 4), rdata[i]);
      end
      for (int i = 0; i < 8; i++)
         expect_read("ram_rand", 32'h0000_0080 + 32'(i * 4), rdata[i]);

      // decode
      write_word(32'h0000_0000, 32'h0BAD_F00D);
      write_word(32'h0000_0100, 32'h5555_5555);
      write_word(32'h0001_0000, 32'h6666_6666);
      write_word(32'hFFFF_0020, 32'h7777_7777);
      expect_read("oor_0100", 32'h0000_0100, 32'd0);
      expect_read("oor_10000", 32'h0001_0000, 32'd0);
      expect_read("oor_ffff0020", 32'hFFFF_0020, 32'd0);
      expect_read("oor_ram0", 32'h0000_0000, 32'h0BAD_F00D);
      expect_read("oor_tcmp", A_TCMP, 32'd0);
      check("oor_gpio_out", gpio_out, 32'd0);

      // GPIO
      write_word(A_GPIO_OUT, 32'h0000_00A5);
      check("gpio_out_pin", gpio_out, 32'h0000_00A5);
      expect_read("gpio_out_rd", A_GPIO_OUT, 32'h0000_00A5);
      gpio_in = 16'h1234;
      expect_read("gpio_in_0edge", A_GPIO_IN, 32'd0);
      tick();
      expect_read("gpio_in_1edge", A_GPIO_IN, 32'd0);
      tick();
      expect_read("gpio_in_2edge", A_GPIO_IN, 32'h0000_1234);

      // timer with auto-clear
      write_word(A_TCMP, 32'd5);
      write_word(A_TCTRL, 32'hB);
      for (int i = 0; i <= 5; i++) begin
         expect_read("tmr_count", A_TCOUNT, 32'(i));
         check("tmr_irq_low", {31'd0, irq}, 32'd0);
         tick();
      end
      expect_read("tmr_autoclr", A_TCOUNT, 32'd0);
      check("tmr_irq_high", {31'd0, irq}, 32'd1);
      expect_read("tmr_flag", A_TCTRL, 32'hF);
      write_word(A_TCTRL, 32'hF);
      check("tmr_irq_clr", {31'd0, irq}, 32'd0);
      expect_read("tmr_ctrl_clr", A_TCTRL, 32'hB);
      expect_read("tmr_count_after_clr", A_TCOUNT, 32'd1);

      // match beats clear: count 1 -> 5, then clear on the matching edge
      for (int i = 0; i < 4; i++) tick();
      expect_read("col_pre", A_TCOUNT, 32'd5);
      write_word(A_TCTRL, 32'hF);
      expect_read("col_flag", A_TCTRL, 32'hF);
      check("col_irq", {31'd0, irq}, 32'd1);

      // TCOUNT load beats increment
      tick();
      write_word(A_TCOUNT, 32'd100);
      expect_read("load_100", A_TCOUNT, 32'd100);
      tick();
      expect_read("load_101", A_TCOUNT, 32'd101);

      // wrap, no auto-clear
      write_word(A_TCTRL, 32'h4);
      write_word(A_TCOUNT, 32'hFFFF_FFFE);
      write_word(A_TCMP, 32'd3);
      write_word(A_TCTRL, 32'h1);
      expect_read("wrap_start", A_TCOUNT, 32'hFFFF_FFFE);
      expect_read("wrap_flag0", A_TCTRL, 32'h1);
      tick();
      expect_read("wrap_ffff", A_TCOUNT, 32'hFFFF_FFFF);
      tick();
      expect_read("wrap_0", A_TCOUNT, 32'd0);
      expect_read("wrap_flag_at0", A_TCTRL, 32'h1);
      tick();
      expect_read("wrap_1", A_TCOUNT, 32'd1);
      tick();
      tick();
      expect_read("wrap_3", A_TCOUNT, 32'd3);
      expect_read("wrap_flag_at3", A_TCTRL, 32'h1);
      tick();
      expect_read("wrap_4", A_TCOUNT, 32'd4);
      expect_read("wrap_flag_set", A_TCTRL, 32'h5);
      check("wrap_irq_masked", {31'd0, irq}, 32'd0);

      // reset mid-run, with a RAM write presented during reset
      reset = 1'b0;
      write_word(32'h0000_0010, 32'hCAFE_CAFE);
      reset = 1'b1;
      check("mrst_gpio_out", gpio_out, 32'd0);
      check("mrst_irq", {31'd0, irq}, 32'd0);
      expect_read("mrst_gpio_out_rd", A_GPIO_OUT, 32'd0);
      expect_read("mrst_gpio_in", A_GPIO_IN, 32'd0);
      expect_read("mrst_tcount", A_TCOUNT, 32'd0);
      expect_read("mrst_tcmp", A_TCMP, 32'd0);
      expect_read("mrst_tctrl", A_TCTRL, 32'd0);
      expect_read("mrst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
      tick();
      tick();
      expect_read("mrst_stopped", A_TCOUNT, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
